hdmi_window_capture: RTL and testbench
======================================

// Module: hdmi_window_capture
// PURPOSE
//  Sits between hdmi_stream and the LED framebuffer RAM, in the hdmi_clk domain.
//  Cuts a WIDTHxHEIGHT window out of the decoded pixel stream and reduces RGB to 8-bit luma.
//  Emits RAM write strobes into one of two banks and flips the bank only on a complete frame,
//  so the LED side never reads a torn frame. Frames are decimated 1-of-DECIMATE.
// PARAMETERS
//  MIN_X       105  first captured hdmi x (inclusive)
//  MIN_Y       110  first captured hdmi y (inclusive)
//  WIDTH       128  window width; power of two
//  HEIGHT      32   window height; power of two
//  ADDR_WIDTH  12   log2(WIDTH*HEIGHT)
//  DECIMATE    1    capture one frame of every DECIMATE (1..255)
// PORTS
//  clk          in   1   hdmi pixel clock
//  reset        in   1   synchronous, active-high
//  valid        in   1   tmds decoder locked
//  vsync        in   1   vertical sync, active low
//  rgb_valid    in   1   r/g/b/xaddr/yaddr carry an active pixel this cycle
//  xaddr,yaddr  in   12  hdmi pixel coordinates
//  r,g,b        in   8   pixel colour
//  wr_en        out  1   RAM write strobe
//  wr_addr      out  ADDR_WIDTH  {y-MIN_Y, x-MIN_X}
//  wr_data      out  8   luma
//  wr_bank      out  1   bank being written; reader uses ~wr_bank
//  frame_done   out  1   one-cycle pulse: bank flipped after a complete frame
//  drop_count   out  8   saturating count of aborted frames
// BEHAVIOUR
//  Reset: state=IDLE, wr_en=0, wr_addr=0, wr_data=0, wr_bank=0, frame_done=0,
//   drop_count=0, decimation counter=0. Reset has priority over everything, mid-frame included.
//  Frame start (sof): registered vsync 1 -> vsync 0 (falling edge); vsync_q resets to 1.
//  Luma: (r + 2*g + b) computed in 10 bits, wr_data = sum[9:2]; never overflows.
//  Pipeline: input pixel at cycle N -> wr_en/wr_addr/wr_data at N+2. Fixed, no stalls.
//  In-window: rgb_valid && MIN_X<=x<MIN_X+WIDTH && MIN_Y<=y<MIN_Y+HEIGHT (12-bit unsigned compares).
//  FSM:
//   IDLE:    wait for valid=1 -> WAIT_SOF.
//   WAIT_SOF: on sof, if dec_cnt==0 -> CAPTURE, else -> SKIP.
//     Either way dec_cnt <= (dec_cnt==DECIMATE-1) ? 0 : dec_cnt+1.
//   CAPTURE: in-window pixels enter pipeline. The last window pixel (x=MIN_X+WIDTH-1,
//     y=MIN_Y+HEIGHT-1) -> DONE once its write has left the pipe.
//     A sof seen here first is an abort: drop_count+1 (holds at 255), no bank flip,
//     frame handled as a new sof from WAIT_SOF in the same cycle.
//   SKIP:    no writes; on sof, act as WAIT_SOF.
//   DONE:    one cycle. wr_bank toggles, frame_done=1 -> WAIT_SOF.
//  valid=0 in any state: -> IDLE next cycle, pipeline flushed (wr_en=0 from next cycle),
//   bank not flipped. An abort from CAPTURE counts in drop_count.
//  wr_en only asserts in CAPTURE (plus pipeline tail). Out-of-window/rgb_valid=0 pixels never write.
//  Write order: any order; a repeated coordinate simply re-writes that address.
//  DECIMATE=1: every frame captured; dec_cnt constantly 0.
// TESTING
//  1 Reset, valid=1, one 800x525 frame with r=g=b=0x40 -> exactly 4096 wr_en pulses,
//    addr 0..4095 in raster order, wr_data=0x40, one frame_done, wr_bank 0->1.
//  2 Pixel (x=105,y=110) r=0xFF,g=0xFF,b=0xFF -> 2 cycles later wr_addr=0, wr_data=0xFF;
//    (232,141) -> wr_addr=0xFFF; (104,110) and (233,110) -> no write.
//  3 Second sof issued after y=120 -> drop_count=1, no frame_done, wr_bank unchanged,
//    next full frame flips bank.
//  4 DECIMATE=3, 6 frames -> writes only in frames 1 and 4; frame_done twice.
//  5 valid dropped mid-window -> wr_en low within 3 cycles, state IDLE, drop_count+1.
//    Re-assert valid -> capture resumes only at the next sof.
//  6 reset pulsed mid-CAPTURE -> all outputs at reset values next cycle.
//    260 aborted frames -> drop_count saturates at 255.

Source files
------------

// File: rtl/hdmi_window_capture.sv
// hdmi_window_capture: cuts a WIDTHxHEIGHT window from the decoded HDMI pixel
// stream, converts it to 8-bit luma and writes it into one of two RAM banks.
// Ports:
//   clk, reset (sync, active-high), valid (decoder lock), vsync (active low)
//   rgb_valid, xaddr, yaddr, r, g, b  : incoming pixel
//   wr_en, wr_addr, wr_data, wr_bank  : RAM write port, bank being written
//   frame_done                        : pulse when the bank flips
//   drop_count                        : saturating count of aborted frames
module hdmi_window_capture #(
  parameter int MIN_X      = 105,
  parameter int MIN_Y      = 110,
  parameter int WIDTH      = 128,
  parameter int HEIGHT     = 32,
  parameter int ADDR_WIDTH = 12,
  parameter int DECIMATE   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid,
  input  logic                  vsync,
  input  logic                  rgb_valid,
  input  logic [11:0]           xaddr,
  input  logic [11:0]           yaddr,
  input  logic [7:0]            r,
  input  logic [7:0]            g,
  input  logic [7:0]            b,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [7:0]            wr_data,
  output logic                  wr_bank,
  output logic                  frame_done,
  output logic [7:0]            drop_count
);

  localparam int XW = $clog2(WIDTH);
  localparam int YW = ADDR_WIDTH - XW;

  localparam logic [11:0] X_LO   = 12'(MIN_X);
  localparam logic [11:0] X_HI   = 12'(MIN_X + WIDTH);
  localparam logic [11:0] Y_LO   = 12'(MIN_Y);
  localparam logic [11:0] Y_HI   = 12'(MIN_Y + HEIGHT);
  localparam logic [11:0] X_LAST = 12'(MIN_X + WIDTH - 1);
  localparam logic [11:0] Y_LAST = 12'(MIN_Y + HEIGHT - 1);
  localparam logic [7:0]  DEC_LAST = 8'(DECIMATE - 1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_SOF,
    CAPTURE,
    SKIP,
    DONE
  } state_e;

  state_e state_q, state_d;
  logic [7:0] dec_q, dec_d;
  logic [7:0] drop_q, drop_d;
  logic       bank_q, bank_d;
  logic       vsync_q;

  logic                  s1_v_q, s1_v_d;
  logic                  s1_last_q, s1_last_d;
  logic [ADDR_WIDTH-1:0] s1_addr_q, s1_addr_d;
  logic [7:0]            s1_data_q, s1_data_d;

  logic                  wr_en_q, wr_en_d;
  logic                  s2_last_q, s2_last_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]            wr_data_q, wr_data_d;

  logic        sof;
  logic        in_win;
  logic        last_px;
  logic        take;
  logic [11:0] x_off;
  logic [11:0] y_off;
  logic [9:0]  sum;
  state_e      sof_state;
  logic [7:0]  dec_nxt;
  logic [7:0]  drop_inc;

  assign sof = vsync_q & ~vsync;

  assign in_win = rgb_valid
                & (xaddr >= X_LO) & (xaddr < X_HI)
                & (yaddr >= Y_LO) & (yaddr < Y_HI);

  assign last_px = (xaddr == X_LAST) & (yaddr == Y_LAST);

  assign x_off = xaddr - X_LO;
  assign y_off = yaddr - Y_LO;

  // Max 4*255 = 1020, so 10 bits never overflow.
  assign sum = {2'b00, r} + {1'b0, g, 1'b0} + {2'b00, b};

  assign take = valid & (state_q == CAPTURE) & in_win;

  // Where a start of frame leads, shared by WAIT_SOF, SKIP and abort.
  assign sof_state = (dec_q == 8'd0) ? CAPTURE : SKIP;
  assign dec_nxt   = (dec_q == DEC_LAST) ? 8'd0 : dec_q + 8'd1;
  assign drop_inc  = (drop_q == 8'hFF) ? drop_q : drop_q + 8'd1;

  always_comb begin
    s1_v_d    = take;
    s1_last_d = take & last_px;
    s1_addr_d = s1_addr_q;
    s1_data_d = s1_data_q;
    if (take) begin
      s1_addr_d = {y_off[YW-1:0], x_off[XW-1:0]};
      s1_data_d = sum[9:2];
    end
    // Dropping valid kills whatever is already in flight.
    wr_en_d   = valid & s1_v_q;
    s2_last_d = valid & s1_last_q;
    wr_addr_d = s1_v_q ? s1_addr_q : wr_addr_q;
    wr_data_d = s1_v_q ? s1_data_q : wr_data_q;
  end

  always_comb begin
    state_d = state_q;
    dec_d   = dec_q;
    drop_d  = drop_q;
    bank_d  = bank_q;
    if (!valid) begin
      state_d = IDLE;
      if (state_q == CAPTURE) drop_d = drop_inc;
    end else begin
      unique case (state_q)
        IDLE: state_d = WAIT_SOF;
        WAIT_SOF, SKIP: begin
          if (sof) begin
            state_d = sof_state;
            dec_d   = dec_nxt;
          end
        end
        CAPTURE: begin
          if (sof) begin
            drop_d  = drop_inc;
            state_d = sof_state;
            dec_d   = dec_nxt;
          end else if (s2_last_q) begin
            // Flip on entry so frame_done and the new bank coincide.
            state_d = DONE;
            bank_d  = ~bank_q;
          end
        end
        DONE: state_d = WAIT_SOF;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      dec_q     <= 8'd0;
      drop_q    <= 8'd0;
      bank_q    <= 1'b0;
      vsync_q   <= 1'b1;
      s1_v_q    <= 1'b0;
      s1_last_q <= 1'b0;
      s1_addr_q <= '0;
      s1_data_q <= 8'd0;
      wr_en_q   <= 1'b0;
      s2_last_q <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      dec_q     <= dec_d;
      drop_q    <= drop_d;
      bank_q    <= bank_d;
      vsync_q   <= vsync;
      s1_v_q    <= s1_v_d;
      s1_last_q <= s1_last_d;
      s1_addr_q <= s1_addr_d;
      s1_data_q <= s1_data_d;
      wr_en_q   <= wr_en_d;
      s2_last_q <= s2_last_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign wr_bank    = bank_q;
  assign frame_done = (state_q == DONE);
  assign drop_count = drop_q;

endmodule

// File: tb/tb_hdmi_window_capture.sv
// tb_hdmi_window_capture: directed bench for hdmi_window_capture.
// Drives a shortened raster around the window into DECIMATE=1 and =3 instances.
module tb_hdmi_window_capture;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        valid = 1'b0;
  logic        vsync = 1'b1;
  logic        rgb_valid = 1'b0;
  logic [11:0] xaddr = '0;
  logic [11:0] yaddr = '0;
  logic [7:0]  r = '0;
  logic [7:0]  g = '0;
  logic [7:0]  b = '0;

  logic        wr_en1, wr_bank1, frame_done1;
  logic [11:0] wr_addr1;
  logic [7:0]  wr_data1, drop1;
  logic        wr_en2, wr_bank2, frame_done2;
  logic [11:0] wr_addr2;
  logic [7:0]  wr_data2, drop2;

  always #5 clk = ~clk;

  hdmi_window_capture #(.DECIMATE(1)) dut1 (
    .clk(clk), .reset(reset), .valid(valid), .vsync(vsync),
    .rgb_valid(rgb_valid), .xaddr(xaddr), .yaddr(yaddr),
    .r(r), .g(g), .b(b),
    .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_data(wr_data1),
    .wr_bank(wr_bank1), .frame_done(frame_done1), .drop_count(drop1)
  );

  hdmi_window_capture #(.DECIMATE(3)) dut2 (
    .clk(clk), .reset(reset), .valid(valid), .vsync(vsync),
    .rgb_valid(rgb_valid), .xaddr(xaddr), .yaddr(yaddr),
    .r(r), .g(g), .b(b),
    .wr_en(wr_en2), .wr_addr(wr_addr2), .wr_data(wr_data2),
    .wr_bank(wr_bank2), .frame_done(frame_done2), .drop_count(drop2)
  );

  int n_chk = 0;
  int n_err = 0;

  // Write monitor; cleared by bumping clr_gen.
  int clr_gen = 0;
  int last_gen = 0;
  int wcnt = 0, addr_err = 0, data_err = 0, exp_addr = 0, fd1 = 0;
  int wcnt2 = 0, fd2 = 0;

  always @(negedge clk) begin
    if (clr_gen != last_gen) begin
      last_gen = clr_gen;
      wcnt = 0; addr_err = 0; data_err = 0; exp_addr = 0;
      fd1 = 0; wcnt2 = 0; fd2 = 0;
    end
    if (wr_en1) begin
      if (wr_addr1 !== exp_addr[11:0]) addr_err++;
      if (wr_data1 !== 8'h40) data_err++;
      exp_addr++;
      wcnt++;
    end
    if (frame_done1) fd1++;
    if (wr_en2) wcnt2++;
    if (frame_done2) fd2++;
  end

  typedef struct {
    logic [11:0] x;
    logic [11:0] y;
    logic [7:0]  r;
    logic [7:0]  g;
    logic [7:0]  b;
    logic        rv;
    logic        en;
    logic [11:0] addr;
    logic [7:0]  data;
  } vec_t;

  vec_t vt[11];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mon_clear();
    clr_gen++;
  endtask

  task automatic pix(input int x, input int y, input logic rv);
    xaddr = 12'(x);
    yaddr = 12'(y);
    r = 8'h40; g = 8'h40; b = 8'h40;
    rgb_valid = rv;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    tick();
  endtask

  // sof, rows 109..last_y over x 104..233, then idle.
  task automatic frame(input int last_y);
    rgb_valid = 1'b0;
    vsync = 1'b0;
    tick(); tick();
    vsync = 1'b1;
    for (int y = 109; y <= last_y; y++)
      for (int x = 104; x <= 233; x++) begin
        pix(x, y, 1'b1);
        tick();
      end
    rgb_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
  endtask

  int w2[6];

  initial begin
    vt[0]  = '{12'd105, 12'd110, 8'hFF, 8'hFF, 8'hFF, 1'b1, 1'b1, 12'h000, 8'hFF};
    vt[1]  = '{12'd104, 12'd110, 8'hFF, 8'hFF, 8'hFF, 1'b1, 1'b0, 12'h000, 8'h00};
    vt[2]  = '{12'd233, 12'd110, 8'hFF, 8'hFF, 8'hFF, 1'b1, 1'b0, 12'h000, 8'h00};
    vt[3]  = '{12'd105, 12'd109, 8'hFF, 8'hFF, 8'hFF, 1'b1, 1'b0, 12'h000, 8'h00};
    vt[4]  = '{12'd105, 12'd142, 8'hFF, 8'hFF, 8'hFF, 1'b1, 1'b0, 12'h000, 8'h00};
    vt[5]  = '{12'd106, 12'd111, 8'h10, 8'h20, 8'h30, 1'b1, 1'b1, 12'h081, 8'h20};
    vt[6]  = '{12'd200, 12'd120, 8'hFF, 8'h00, 8'h00, 1'b1, 1'b1, 12'h55F, 8'h3F};
    vt[7]  = '{12'd150, 12'd130, 8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b0, 12'h000, 8'h00};
    vt[8]  = '{12'd232, 12'd110, 8'h00, 8'hFF, 8'h00, 1'b1, 1'b1, 12'h07F, 8'h7F};
    vt[9]  = '{12'd105, 12'd141, 8'h01, 8'h02, 8'h03, 1'b1, 1'b1, 12'hF80, 8'h02};
    vt[10] = '{12'd232, 12'd141, 8'hFF, 8'hFF, 8'hFF, 1'b1, 1'b1, 12'hFFF, 8'hFF};

    // Reset values
    valid = 1'b1;
    reset = 1'b1;
    tick(); tick();
    chk("rst_wr_en", wr_en1, 0);
    chk("rst_wr_addr", wr_addr1, 0);
    chk("rst_wr_data", wr_data1, 0);
    chk("rst_wr_bank", wr_bank1, 0);
    chk("rst_frame_done", frame_done1, 0);
    chk("rst_drop", drop1, 0);
    reset = 1'b0;
    tick();

    // Full frame, flat grey
    mon_clear();
    frame(142);
    chk("t1_writes", wcnt, 4096);
    chk("t1_addr_order", addr_err, 0);
    chk("t1_data", data_err, 0);
    chk("t1_frame_done", fd1, 1);
    chk("t1_bank", wr_bank1, 1);

    // Abort after y=120, then a full frame
    mon_clear();
    frame(120);
    chk("t3_fd_partial", fd1, 0);
    chk("t3_bank_partial", wr_bank1, 1);
    mon_clear();
    frame(142);
    chk("t3_drop", drop1, 1);
    chk("t3_fd_full", fd1, 1);
    chk("t3_writes", wcnt, 4096);
    chk("t3_addr_order", addr_err, 0);
    chk("t3_bank_full", wr_bank1, 0);

    // Single-pixel vectors, latency 2
    vsync = 1'b0;
    tick();
    vsync = 1'b1;
    tick();
    for (int i = 0; i < 11; i++) begin
      xaddr = vt[i].x; yaddr = vt[i].y;
      r = vt[i].r; g = vt[i].g; b = vt[i].b;
      rgb_valid = vt[i].rv;
      tick();
      rgb_valid = 1'b0;
      tick();
      chk($sformatf("vec%0d_en", i), wr_en1, vt[i].en);
      if (vt[i].en) begin
        chk($sformatf("vec%0d_addr", i), wr_addr1, vt[i].addr);
        chk($sformatf("vec%0d_data", i), wr_data1, vt[i].data);
      end
    end
    tick();
    chk("t2_frame_done", frame_done1, 1);
    chk("t2_bank", wr_bank1, 1);
    tick();
    chk("t2_frame_done_off", frame_done1, 0);

    // Reset in the middle of a capture
    frame(115);
    pix(105, 116, 1'b1);
    tick();
    pix(106, 116, 1'b1);
    tick();
    chk("t6_pre_wr_en", wr_en1, 1);
    chk("t6_pre_addr", wr_addr1, 12'd768);
    pix(107, 116, 1'b1);
    reset = 1'b1;
    tick();
    chk("t6_wr_en", wr_en1, 0);
    chk("t6_wr_addr", wr_addr1, 0);
    chk("t6_wr_data", wr_data1, 0);
    chk("t6_wr_bank", wr_bank1, 0);
    chk("t6_frame_done", frame_done1, 0);
    chk("t6_drop", drop1, 0);
    reset = 1'b0;
    rgb_valid = 1'b0;
    tick();

    // Decimation by 3 over six frames
    do_reset();
    for (int f = 0; f < 6; f++) begin
      mon_clear();
      frame(142);
      w2[f] = wcnt2;
      chk($sformatf("t4_fd_f%0d", f + 1), fd2, (f == 0 || f == 3) ? 1 : 0);
    end
    chk("t4_w_f1", w2[0], 4096);
    chk("t4_w_f2", w2[1], 0);
    chk("t4_w_f3", w2[2], 0);
    chk("t4_w_f4", w2[3], 4096);
    chk("t4_w_f5", w2[4], 0);
    chk("t4_w_f6", w2[5], 0);

    // valid dropped mid-window
    do_reset();
    frame(115);
    for (int x = 105; x <= 150; x++) begin
      pix(x, 116, 1'b1);
      tick();
    end
    valid = 1'b0;
    for (int x = 151; x <= 153; x++) begin
      pix(x, 116, 1'b1);
      tick();
    end
    chk("t5_wr_en_off", wr_en1, 0);
    chk("t5_drop", drop1, 1);
    tick();
    mon_clear();
    valid = 1'b1;
    for (int x = 105; x <= 232; x++) begin
      pix(x, 117, 1'b1);
      tick();
    end
    rgb_valid = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("t5_no_write_before_sof", wcnt, 0);
    mon_clear();
    vsync = 1'b0;
    tick(); tick();
    vsync = 1'b1;
    for (int x = 105; x <= 114; x++) begin
      pix(x, 110, 1'b1);
      tick();
    end
    rgb_valid = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("t5_resume_writes", wcnt, 10);
    chk("t5_resume_addr", addr_err, 0);
    chk("t5_resume_data", data_err, 0);

    // drop_count saturation
    do_reset();
    for (int i = 1; i <= 260; i++) begin
      vsync = 1'b0;
      tick();
      vsync = 1'b1;
      tick();
      if (i == 100) chk("t6_drop_99", drop1, 99);
      if (i == 256) chk("t6_drop_255", drop1, 255);
    end
    chk("t6_drop_sat", drop1, 255);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
